// File: rtl/uart_demux_pkg.sv
// ---------------------------------------------------------------------------
// uart_demux_pkg
// Shared UART game-link protocol definitions. The transmit mux and the receive
// demux both import this package.
//   - Word layout : {tag[3:0], payload[11:0]}, high byte sent first
//   - Tags        : MATCH_CTRL, PL1_POSX, PL1_POSY, BALL_POSX, BALL_POSY
//   - Match-control payload bit positions
// No ports (package).
// ---------------------------------------------------------------------------
package uart_demux_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned PAYLOAD_W = 12;
  localparam int unsigned POS_W     = 12;
  localparam int unsigned SCORE_W   = 4;

  // Word tags
  localparam logic [TAG_W-1:0] MATCH_CTRL = 4'h0;
  localparam logic [TAG_W-1:0] PL1_POSX   = 4'h3;
  localparam logic [TAG_W-1:0] PL1_POSY   = 4'h4;
  localparam logic [TAG_W-1:0] BALL_POSX  = 4'h5;
  localparam logic [TAG_W-1:0] BALL_POSY  = 4'h6;

  // Match-control payload bit positions (payload[11] is reserved)
  localparam int unsigned MC_PL1_SCORE_LSB = 0;
  localparam int unsigned MC_PL2_SCORE_LSB = 4;
  localparam int unsigned MC_FLAG_POINT    = 8;
  localparam int unsigned MC_END_GAME      = 9;
  localparam int unsigned MC_WHISTLE       = 10;

  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [PAYLOAD_W-1:0] payload;
  } word_t;

  typedef struct packed {
    logic               whistle;
    logic               end_game;
    logic               flag_point;
    logic [SCORE_W-1:0] pl2_score;
    logic [SCORE_W-1:0] pl1_score;
  } match_t;

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } asm_state_e;

endpackage

// File: rtl/uart_8to16.sv
// ---------------------------------------------------------------------------
// uart_8to16
// Byte-pair assembler: joins two received bytes (high first) into a 16-bit
// word, with an inter-byte timeout that drops a stranded high byte.
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   rx_done_i    in   one-cycle strobe, rx_data_i valid
//   rx_data_i    in   received byte
//   word_o       out  last assembled word (held)
//   word_valid_o out  one-cycle strobe, word_o freshly updated
//   sync_err_o   out  one-cycle strobe on inter-byte timeout
// Parameter TIMEOUT_CYCLES (>= 1): idle cycles allowed between the two bytes.
// ---------------------------------------------------------------------------
module uart_8to16
  import uart_demux_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done_i,
  input  logic [BYTE_W-1:0] rx_data_i,
  output word_t             word_o,
  output logic              word_valid_o,
  output logic              sync_err_o
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  asm_state_e        state_q, state_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  word_t             word_q, word_d;
  logic              word_valid_q, word_valid_d;
  logic              sync_err_q, sync_err_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_HI;
      hi_q         <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Next state; a low byte arriving on the expiry cycle wins over the timeout
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    unique case (state_q)
      WAIT_HI: begin
        if (rx_done_i) begin
          hi_d    = rx_data_i;
          cnt_d   = '0;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (rx_done_i) begin
          word_d       = word_t'({hi_q, rx_data_i});
          word_valid_d = 1'b1;
          state_d      = WAIT_HI;
        end else if (cnt_q >= CNT_LAST) begin
          hi_d       = '0;
          sync_err_d = 1'b1;
          state_d    = WAIT_HI;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = WAIT_HI;
    endcase
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;
  assign sync_err_o   = sync_err_q;

endmodule

// File: rtl/uart_demux.sv
// ---------------------------------------------------------------------------
// uart_demux
// Receive-side demux for the game link: assembles byte pairs into tagged
// words (uart_8to16) and decodes them into registered game-state outputs.
// Ports:
//   clk, rst                       clock / synchronous active-high reset
//   rx_done, rx_data               received byte strobe and data
//   pl1_posx, pl1_posy             player-1 position (12b each)
//   ball_posx, ball_posy           ball position (12b each)
//   pl1_score, pl2_score           scores (4b each)
//   flag_point, end_game, whistle  match-control levels
//   word_valid                     one-cycle strobe per assembled word
//   sync_err                       one-cycle strobe on inter-byte timeout
// Macro UART_DEMUX_ATOMIC_EN: when defined, MATCH_CTRL/PL1_POSX/PL1_POSY/
// BALL_POSX go to shadow registers and a BALL_POSY word commits the whole
// frame at once. Undefined: every tag updates its outputs directly.
// ---------------------------------------------------------------------------
module uart_demux
  import uart_demux_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_done,
  input  logic [BYTE_W-1:0]  rx_data,
  output logic [POS_W-1:0]   pl1_posx,
  output logic [POS_W-1:0]   pl1_posy,
  output logic [POS_W-1:0]   ball_posx,
  output logic [POS_W-1:0]   ball_posy,
  output logic [SCORE_W-1:0] pl1_score,
  output logic [SCORE_W-1:0] pl2_score,
  output logic               flag_point,
  output logic               end_game,
  output logic               whistle,
  output logic               word_valid,
  output logic               sync_err
);

  word_t word;

  uart_8to16 #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_asm (
    .clk          (clk),
    .rst          (rst),
    .rx_done_i    (rx_done),
    .rx_data_i    (rx_data),
    .word_o       (word),
    .word_valid_o (word_valid),
    .sync_err_o   (sync_err)
  );

  logic [POS_W-1:0] pl1_posx_q, pl1_posx_d;
  logic [POS_W-1:0] pl1_posy_q, pl1_posy_d;
  logic [POS_W-1:0] ball_posx_q, ball_posx_d;
  logic [POS_W-1:0] ball_posy_q, ball_posy_d;
  match_t           mc_q, mc_d;
  match_t           mc_word;

  // Match-control fields carried by the current word's payload
  always_comb begin
    mc_word            = '0;
    mc_word.pl1_score  = word.payload[MC_PL1_SCORE_LSB +: SCORE_W];
    mc_word.pl2_score  = word.payload[MC_PL2_SCORE_LSB +: SCORE_W];
    mc_word.flag_point = word.payload[MC_FLAG_POINT];
    mc_word.end_game   = word.payload[MC_END_GAME];
    mc_word.whistle    = word.payload[MC_WHISTLE];
  end

`ifdef UART_DEMUX_ATOMIC_EN
  logic [POS_W-1:0] sh_pl1_posx_q, sh_pl1_posx_d;
  logic [POS_W-1:0] sh_pl1_posy_q, sh_pl1_posy_d;
  logic [POS_W-1:0] sh_ball_posx_q, sh_ball_posx_d;
  match_t           sh_mc_q, sh_mc_d;

  // Shadow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_pl1_posx_q  <= '0;
      sh_pl1_posy_q  <= '0;
      sh_ball_posx_q <= '0;
      sh_mc_q        <= '0;
    end else begin
      sh_pl1_posx_q  <= sh_pl1_posx_d;
      sh_pl1_posy_q  <= sh_pl1_posy_d;
      sh_ball_posx_q <= sh_ball_posx_d;
      sh_mc_q        <= sh_mc_d;
    end
  end

  // Decode: stage into shadows, BALL_POSY closes the frame and commits all
  always_comb begin
    pl1_posx_d     = pl1_posx_q;
    pl1_posy_d     = pl1_posy_q;
    ball_posx_d    = ball_posx_q;
    ball_posy_d    = ball_posy_q;
    mc_d           = mc_q;
    sh_pl1_posx_d  = sh_pl1_posx_q;
    sh_pl1_posy_d  = sh_pl1_posy_q;
    sh_ball_posx_d = sh_ball_posx_q;
    sh_mc_d        = sh_mc_q;
    if (word_valid) begin
      unique case (word.tag)
        MATCH_CTRL: sh_mc_d        = mc_word;
        PL1_POSX:   sh_pl1_posx_d  = word.payload;
        PL1_POSY:   sh_pl1_posy_d  = word.payload;
        BALL_POSX:  sh_ball_posx_d = word.payload;
        BALL_POSY: begin
          pl1_posx_d  = sh_pl1_posx_q;
          pl1_posy_d  = sh_pl1_posy_q;
          ball_posx_d = sh_ball_posx_q;
          mc_d        = sh_mc_q;
          ball_posy_d = word.payload;
        end
        default: ;
      endcase
    end
  end
`else
  // Decode: each recognised tag updates its own outputs directly
  always_comb begin
    pl1_posx_d  = pl1_posx_q;
    pl1_posy_d  = pl1_posy_q;
    ball_posx_d = ball_posx_q;
    ball_posy_d = ball_posy_q;
    mc_d        = mc_q;
    if (word_valid) begin
      unique case (word.tag)
        MATCH_CTRL: mc_d        = mc_word;
        PL1_POSX:   pl1_posx_d  = word.payload;
        PL1_POSY:   pl1_posy_d  = word.payload;
        BALL_POSX:  ball_posx_d = word.payload;
        BALL_POSY:  ball_posy_d = word.payload;
        default: ;
      endcase
    end
  end
`endif

  // Decoded output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pl1_posx_q  <= '0;
      pl1_posy_q  <= '0;
      ball_posx_q <= '0;
      ball_posy_q <= '0;
      mc_q        <= '0;
    end else begin
      pl1_posx_q  <= pl1_posx_d;
      pl1_posy_q  <= pl1_posy_d;
      ball_posx_q <= ball_posx_d;
      ball_posy_q <= ball_posy_d;
      mc_q        <= mc_d;
    end
  end

  assign pl1_posx   = pl1_posx_q;
  assign pl1_posy   = pl1_posy_q;
  assign ball_posx  = ball_posx_q;
  assign ball_posy  = ball_posy_q;
  assign pl1_score  = mc_q.pl1_score;
  assign pl2_score  = mc_q.pl2_score;
  assign flag_point = mc_q.flag_point;
  assign end_game   = mc_q.end_game;
  assign whistle    = mc_q.whistle;

endmodule

// File: tb/tb_uart_demux.sv
// ---------------------------------------------------------------------------
// tb_uart_demux
// Directed self-checking bench for uart_demux with a short timeout.
// Inputs change and outputs are sampled on the falling clock edge.
// Macro UART_DEMUX_ATOMIC_EN selects the shadow/commit scenario.
// ---------------------------------------------------------------------------
module tb_uart_demux;

  localparam int unsigned TO = 16;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
  logic [3:0]  pl1_score, pl2_score;
  logic        flag_point, end_game, whistle, word_valid, sync_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int wv_cnt = 0;
  int se_cnt = 0;
  int wv_base, se_base;

  uart_demux #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .pl1_posx   (pl1_posx),
    .pl1_posy   (pl1_posy),
    .ball_posx  (ball_posx),
    .ball_posy  (ball_posy),
    .pl1_score  (pl1_score),
    .pl2_score  (pl2_score),
    .flag_point (flag_point),
    .end_game   (end_game),
    .whistle    (whistle),
    .word_valid (word_valid),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  // Pulse counters (NBA so same-edge readers see the previous count)
  always @(negedge clk) begin
    if (word_valid === 1'b1) wv_cnt <= wv_cnt + 1;
    if (sync_err === 1'b1)   se_cnt <= se_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge: presents one byte for one cycle
  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({pl1_posx, pl1_posy, ball_posx, ball_posy} !== 48'h0) begin
      $display("FAIL reset_pos: got %h expected %h", {pl1_posx, pl1_posy, ball_posx, ball_posy}, 48'h0);
      n_fail++;
    end
    n_cmp++;
    if ({pl1_score, pl2_score} !== 8'h00) begin
      $display("FAIL reset_score: got %h expected %h", {pl1_score, pl2_score}, 8'h00);
      n_fail++;
    end
    n_cmp++;
    if ({flag_point, end_game, whistle} !== 3'b000) begin
      $display("FAIL reset_flags: got %b expected %b", {flag_point, end_game, whistle}, 3'b000);
      n_fail++;
    end
    n_cmp++;
    if ({word_valid, sync_err} !== 2'b00) begin
      $display("FAIL reset_strobes: got %b expected %b", {word_valid, sync_err}, 2'b00);
      n_fail++;
    end
  endtask

  task automatic test_posx;
    wv_base = wv_cnt;
    send_byte(8'h3A);
    send_byte(8'hBC);
    // word_valid cycle: strobe high, outputs not yet updated
    n_cmp++;
    if (word_valid !== 1'b1) begin
      $display("FAIL posx_wv_strobe: got %b expected %b", word_valid, 1'b1);
      n_fail++;
    end
    n_cmp++;
    if (pl1_posx !== 12'h000) begin
      $display("FAIL posx_early: got %h expected %h", pl1_posx, 12'h000);
      n_fail++;
    end
    @(negedge clk);
    n_cmp++;
    if (pl1_posx !== 12'hABC) begin
      $display("FAIL posx_value: got %h expected %h", pl1_posx, 12'hABC);
      n_fail++;
    end
    n_cmp++;
    if (wv_cnt - wv_base !== 1) begin
      $display("FAIL posx_wv_count: got %0d expected %0d", wv_cnt - wv_base, 1);
      n_fail++;
    end
  endtask

  task automatic test_match_ctrl;
    send_byte(8'h07);
    send_byte(8'h5A);
    @(negedge clk);
    n_cmp++;
    if ({pl1_score, pl2_score} !== 8'hA5) begin
      $display("FAIL mc_scores: got %h expected %h", {pl1_score, pl2_score}, 8'hA5);
      n_fail++;
    end
    n_cmp++;
    if ({flag_point, end_game, whistle} !== 3'b111) begin
      $display("FAIL mc_flags: got %b expected %b", {flag_point, end_game, whistle}, 3'b111);
      n_fail++;
    end
    n_cmp++;
    if (pl1_posx !== 12'hABC) begin
      $display("FAIL mc_posx_hold: got %h expected %h", pl1_posx, 12'hABC);
      n_fail++;
    end
    // payload 0x800: only the reserved bit set
    send_byte(8'h08);
    send_byte(8'h00);
    @(negedge clk);
    n_cmp++;
    if ({pl1_score, pl2_score, flag_point, end_game, whistle} !== 11'h000) begin
      $display("FAIL mc_bit11: got %h expected %h",
               {pl1_score, pl2_score, flag_point, end_game, whistle}, 11'h000);
      n_fail++;
    end
  endtask

  task automatic test_unknown_tag;
    wv_base = wv_cnt;
    send_byte(8'hF1);
    send_byte(8'h23);
    @(negedge clk);
    send_byte(8'h71);
    send_byte(8'h23);
    @(negedge clk);
    n_cmp++;
    if (wv_cnt - wv_base !== 2) begin
      $display("FAIL unk_wv_count: got %0d expected %0d", wv_cnt - wv_base, 2);
      n_fail++;
    end
    n_cmp++;
    if ({pl1_posx, pl1_posy, ball_posx, ball_posy} !== {12'hABC, 12'h000, 12'h000, 12'h000}) begin
      $display("FAIL unk_pos: got %h expected %h", {pl1_posx, pl1_posy, ball_posx, ball_posy},
               {12'hABC, 12'h000, 12'h000, 12'h000});
      n_fail++;
    end
    n_cmp++;
    if ({pl1_score, pl2_score, flag_point, end_game, whistle} !== 11'h000) begin
      $display("FAIL unk_mc: got %h expected %h",
               {pl1_score, pl2_score, flag_point, end_game, whistle}, 11'h000);
      n_fail++;
    end
  endtask

  task automatic test_timeout;
    wv_base = wv_cnt;
    se_base = se_cnt;
    send_byte(8'h5F);
    repeat (TO) @(negedge clk);
    send_byte(8'h41);
    send_byte(8'h23);
    @(negedge clk);
    n_cmp++;
    if (se_cnt - se_base !== 1) begin
      $display("FAIL to_sync_err: got %0d expected %0d", se_cnt - se_base, 1);
      n_fail++;
    end
    n_cmp++;
    if (ball_posx !== 12'h000) begin
      $display("FAIL to_ballx: got %h expected %h", ball_posx, 12'h000);
      n_fail++;
    end
    n_cmp++;
    if (pl1_posy !== 12'h123) begin
      $display("FAIL to_posy: got %h expected %h", pl1_posy, 12'h123);
      n_fail++;
    end
    n_cmp++;
    if (wv_cnt - wv_base !== 1) begin
      $display("FAIL to_wv_count: got %0d expected %0d", wv_cnt - wv_base, 1);
      n_fail++;
    end
  endtask

  task automatic test_timeout_boundary;
    se_base = se_cnt;
    send_byte(8'h5F);
    // low byte lands on the expiry cycle
    repeat (TO - 1) @(negedge clk);
    send_byte(8'h01);
    @(negedge clk);
    n_cmp++;
    if (se_cnt - se_base !== 0) begin
      $display("FAIL tob_sync_err: got %0d expected %0d", se_cnt - se_base, 0);
      n_fail++;
    end
    n_cmp++;
    if (ball_posx !== 12'hF01) begin
      $display("FAIL tob_ballx: got %h expected %h", ball_posx, 12'hF01);
      n_fail++;
    end
  endtask

  task automatic test_reset_midword;
    se_base = se_cnt;
    send_byte(8'h3A);
    rst     = 1'b1;
    rx_done = 1'b1;
    rx_data = 8'h3A;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({pl1_posx, pl1_posy, ball_posx, ball_posy} !== 48'h0) begin
      $display("FAIL rmw_cleared: got %h expected %h", {pl1_posx, pl1_posy, ball_posx, ball_posy}, 48'h0);
      n_fail++;
    end
    repeat (TO + 2) @(negedge clk);
    send_byte(8'h40);
    send_byte(8'h05);
    @(negedge clk);
    n_cmp++;
    if (se_cnt - se_base !== 0) begin
      $display("FAIL rmw_sync_err: got %0d expected %0d", se_cnt - se_base, 0);
      n_fail++;
    end
    n_cmp++;
    if (pl1_posx !== 12'h000) begin
      $display("FAIL rmw_posx: got %h expected %h", pl1_posx, 12'h000);
      n_fail++;
    end
    n_cmp++;
    if (pl1_posy !== 12'h005) begin
      $display("FAIL rmw_posy: got %h expected %h", pl1_posy, 12'h005);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    wv_base = wv_cnt;
    send_byte(8'h51);
    send_byte(8'h11);
    send_byte(8'h62);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h33);
    @(negedge clk);
    n_cmp++;
    if ({ball_posx, ball_posy, pl1_posx} !== {12'h111, 12'h222, 12'h333}) begin
      $display("FAIL b2b_pos: got %h expected %h", {ball_posx, ball_posy, pl1_posx},
               {12'h111, 12'h222, 12'h333});
      n_fail++;
    end
    n_cmp++;
    if (wv_cnt - wv_base !== 3) begin
      $display("FAIL b2b_wv_count: got %0d expected %0d", wv_cnt - wv_base, 3);
      n_fail++;
    end
  endtask

  task automatic test_atomic;
    send_byte(8'h31);
    send_byte(8'h11);
    @(negedge clk);
    n_cmp++;
    if (pl1_posx !== 12'h000) begin
      $display("FAIL atom_posx_staged: got %h expected %h", pl1_posx, 12'h000);
      n_fail++;
    end
    send_byte(8'h07);
    send_byte(8'h5A);
    @(negedge clk);
    n_cmp++;
    if ({pl1_score, pl2_score} !== 8'h00) begin
      $display("FAIL atom_mc_staged: got %h expected %h", {pl1_score, pl2_score}, 8'h00);
      n_fail++;
    end
    send_byte(8'h62);
    send_byte(8'h22);
    n_cmp++;
    if ({pl1_posx, ball_posy} !== 24'h000000) begin
      $display("FAIL atom_pre_commit: got %h expected %h", {pl1_posx, ball_posy}, 24'h000000);
      n_fail++;
    end
    @(negedge clk);
    n_cmp++;
    if ({pl1_posx, ball_posy} !== {12'h111, 12'h222}) begin
      $display("FAIL atom_commit: got %h expected %h", {pl1_posx, ball_posy}, {12'h111, 12'h222});
      n_fail++;
    end
    n_cmp++;
    if ({pl1_score, pl2_score, flag_point, end_game, whistle} !== {8'hA5, 3'b111}) begin
      $display("FAIL atom_mc_commit: got %h expected %h",
               {pl1_score, pl2_score, flag_point, end_game, whistle}, {8'hA5, 3'b111});
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
`ifdef UART_DEMUX_ATOMIC_EN
    test_atomic();
`else
    test_posx();
    test_match_ctrl();
    test_unknown_tag();
    test_timeout();
    test_timeout_boundary();
    test_reset_midword();
    test_back_to_back();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_demux.md
UART_DEMUX -- requirements
Module: uart_demux

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, is the maximum idle clk cycles allowed between the high and low byte of one word.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rx_done  input  1  one-cycle strobe; rx_data holds a valid received byte.
REQ-005 rx_data  input  8  received UART byte.
REQ-006 pl1_posx, pl1_posy, ball_posx, ball_posy  output  12 each  decoded positions, registered.
REQ-007 pl1_score, pl2_score  output  4 each  decoded scores, registered.
REQ-008 flag_point, end_game, whistle  output  1 each  decoded match-control flags, registered levels.
REQ-009 word_valid  output  1  one-cycle strobe per assembled 16-bit word.
REQ-010 sync_err  output  1  one-cycle strobe on inter-byte timeout.

Function
REQ-011 Each word SHALL be 16 bits, {tag[3:0], payload[11:0]}, high byte received first.
REQ-012 Assembler FSM SHALL have states WAIT_HI and WAIT_LO; reset state WAIT_HI.
REQ-013 WAIT_HI + rx_done SHALL latch rx_data as high byte, clear the timeout counter, and go to WAIT_LO.
REQ-014 WAIT_LO + rx_done SHALL form the word, pulse word_valid the next cycle, and return to WAIT_HI.
REQ-015 In WAIT_LO, when the counter reaches TIMEOUT_CYCLES without rx_done, the FSM SHALL discard the high byte, pulse sync_err for one cycle, and return to WAIT_HI.
REQ-016 rx_done in the same cycle the timeout expires SHALL be treated as the low byte; no sync_err.
REQ-017 The timeout counter SHALL saturate and never wrap.
REQ-018 Decoding SHALL occur in the word_valid cycle; outputs SHALL change on the clk edge ending that cycle (2 cycles after the low-byte rx_done).
REQ-019 Tag 0x3 -> pl1_posx, 0x4 -> pl1_posy, 0x5 -> ball_posx, 0x6 -> ball_posy, each taking payload[11:0].
REQ-020 Tag 0x0 SHALL load pl1_score=payload[3:0], pl2_score=payload[7:4], flag_point=payload[8], end_game=payload[9], whistle=payload[10]; payload[11] ignored.
REQ-021 All other tags SHALL pulse word_valid but leave every decoded output unchanged.
REQ-022 Decoded outputs SHALL hold their values between updates.

Reset
REQ-023 On rst, all outputs, the FSM, the byte latch and the counter SHALL clear to 0 / WAIT_HI in the same cycle.
REQ-024 rst asserted mid-word SHALL discard the partial word without a sync_err pulse.
REQ-025 rx_done during rst SHALL be ignored.

Configuration
REQ-026 Macro UART_DEMUX_ATOMIC_EN defined: tags 0x0 and 0x3-0x5 SHALL write shadow registers, and tag 0x6 SHALL copy all shadows plus the new ball_posy to the outputs on the same edge.
REQ-027 Macro UART_DEMUX_ATOMIC_EN undefined: no shadow registers; each tag SHALL update its outputs immediately per REQ-018.
REQ-028 Shadow registers SHALL reset to 0.

Structure
REQ-029 Tag localparams (MATCH_CTRL=0x0, PL1_POSX=0x3, PL1_POSY=0x4, BALL_POSX=0x5, BALL_POSY=0x6) and the match-control bit positions SHALL live in the shared protocol package used by the transmit mux.
REQ-030 The byte-pair assembler (FSM, timeout, word_valid, sync_err) SHALL be a sub-module named uart_8to16; uart_demux instantiates it and contains the decode.

Verification
REQ-031 Bytes 0x3A, 0xBC -> two cycles after the second rx_done, pl1_posx=0xABC and word_valid has pulsed once.
REQ-032 Bytes 0x07, 0x5A (tag 0) -> pl1_score=0xA, pl2_score=0x5, flag_point=1, end_game=1, whistle=1.
REQ-033 Byte 0x5F followed by a gap of TIMEOUT_CYCLES, then bytes 0x41, 0x23 -> one sync_err pulse, ball_posx unchanged by 0x5F, pl1_posy=0x123.
REQ-034 Bytes 0xF1, 0x23 (tag 0xF) -> word_valid pulses; all decoded outputs unchanged.
REQ-035 With UART_DEMUX_ATOMIC_EN, words tagged 0x3 (0x111) then 0x6 (0x222) -> pl1_posx stays 0 after the first word, then pl1_posx=0x111 and ball_posy=0x222 update on the same edge.
REQ-036 rst asserted after byte 0x3A, then bytes 0x40, 0x05 after release -> no sync_err, pl1_posx=0, pl1_posy=0x005.
